// File: rtl/min_max.sv
// Registered binary32 FMIN.S/FMAX.S unit with RISC-V NaN, signed-zero and NV rules.
// Define MIN_MAX_STICKY_INVALID_EN to make Invalid accumulate until rst.
module min_max (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rm,
  input  logic        in_valid,
  output logic [31:0] s,
  output logic        Invalid,
  output logic        out_valid
);

  logic        w_aIsNan;
  logic        w_bIsNan;
  logic        w_anySnan;
  logic        w_aLess;
  logic [31:0] w_ordered;
  logic [31:0] w_result;

  logic [31:0] r_s;
  logic        r_invalid;
  logic        r_outValid;

  assign w_aIsNan  = (&a[30:23]) && (|a[22:0]);
  assign w_bIsNan  = (&b[30:23]) && (|b[22:0]);
  assign w_anySnan = (w_aIsNan && !a[22]) || (w_bIsNan && !b[22]);

  // Sign-magnitude total order: -0 sorts below +0 through the sign-differs case.
  always_comb begin
    w_aLess = 1'b0;
    if (a[31] != b[31])
      w_aLess = a[31];
    else if (!a[31])
      w_aLess = a[30:0] < b[30:0];
    else
      w_aLess = a[30:0] > b[30:0];
  end

  always_comb begin
    w_ordered = (rm ^ w_aLess) ? a : b;
    w_result  = w_ordered;
    if (w_aIsNan && w_bIsNan)
      w_result = 32'h7FC00000;
    else if (w_aIsNan)
      w_result = b;
    else if (w_bIsNan)
      w_result = a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s        <= 32'h00000000;
      r_invalid  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= in_valid;
      if (in_valid)
        r_s <= w_result;
`ifdef MIN_MAX_STICKY_INVALID_EN
      r_invalid <= r_invalid | (in_valid & w_anySnan);
`else
      r_invalid <= in_valid & w_anySnan;
`endif
    end
  end

  assign s         = r_s;
  assign Invalid   = r_invalid;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_min_max.sv
// Directed, table-driven bench for min_max: ordering, NaN/NV rules, hold, and reset.
// Expected Invalid follows the accumulated model when MIN_MAX_STICKY_INVALID_EN is defined.
module tb_min_max;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        rm;
      logic [31:0] expS;
      logic        expInv;
   } vector_t;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic        rm;
   logic        in_valid;
   logic [31:0] s;
   logic        Invalid;
   logic        out_valid;

   int applied;
   int miscompares;
   logic stickyModel;
   logic [31:0] lastS;

   vector_t vecs[21];

   min_max dut (
      .clk(clk),
      .rst(rst),
      .a(a),
      .b(b),
      .rm(rm),
      .in_valid(in_valid),
      .s(s),
      .Invalid(Invalid),
      .out_valid(out_valid)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request (or idle) on the inputs; takes effect at the next rising edge.
   task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                input logic vrm, input logic vvalid);
      a        = va;
      b        = vb;
      rm       = vrm;
      in_valid = vvalid;
   endtask

   // Step past the next rising edge and compare all outputs at the falling edge.
   task automatic checkOutput(input string name, input logic [31:0] expS,
                              input logic expInv, input logic expValid);
      @(negedge clk);
      applied++;
      if (s !== expS || Invalid !== expInv || out_valid !== expValid) begin
         miscompares++;
         $display("[TB] FAIL %s: got s=%h Invalid=%b out_valid=%b, expected s=%h Invalid=%b out_valid=%b",
                  name, s, Invalid, out_valid, expS, expInv, expValid);
      end
   endtask

   function automatic logic expectedInvalid(input logic reqInv);
`ifdef MIN_MAX_STICKY_INVALID_EN
      stickyModel = stickyModel | reqInv;
      return stickyModel;
`else
      return reqInv;
`endif
   endfunction

   initial begin
      applied     = 0;
      miscompares = 0;
      stickyModel = 1'b0;

      vecs[0]  = '{32'h40200000, 32'h40200000, 1'b0, 32'h40200000, 1'b0};
      vecs[1]  = '{32'h40200000, 32'h40200000, 1'b1, 32'h40200000, 1'b0};
      vecs[2]  = '{32'h3FC00000, 32'h40200000, 1'b0, 32'h3FC00000, 1'b0};
      vecs[3]  = '{32'h3FC00000, 32'h40200000, 1'b1, 32'h40200000, 1'b0};
      vecs[4]  = '{32'h40200000, 32'h3FC00000, 1'b0, 32'h3FC00000, 1'b0};
      vecs[5]  = '{32'h40200000, 32'h3FC00000, 1'b1, 32'h40200000, 1'b0};
      vecs[6]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 1'b0};
      vecs[7]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
      vecs[8]  = '{32'hC0200000, 32'hBFC00000, 1'b0, 32'hC0200000, 1'b0};
      vecs[9]  = '{32'hC0200000, 32'hBFC00000, 1'b1, 32'hBFC00000, 1'b0};
      vecs[10] = '{32'h7FC00000, 32'h3FC00000, 1'b0, 32'h3FC00000, 1'b0};
      vecs[11] = '{32'h3FC00000, 32'h7FC00000, 1'b1, 32'h3FC00000, 1'b0};
      vecs[12] = '{32'h7FC00000, 32'hFFC00000, 1'b1, 32'h7FC00000, 1'b0};
      vecs[13] = '{32'hFF800000, 32'h7F7FFFFF, 1'b0, 32'hFF800000, 1'b0};
      vecs[14] = '{32'h7F800000, 32'h00000001, 1'b1, 32'h7F800000, 1'b0};
      vecs[15] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000001, 1'b0};
      vecs[16] = '{32'h80000001, 32'h80000002, 1'b1, 32'h80000001, 1'b0};
      vecs[17] = '{32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0};
      vecs[18] = '{32'h7F800001, 32'h40200000, 1'b1, 32'h40200000, 1'b1};
      vecs[19] = '{32'h7F800001, 32'h7F800001, 1'b0, 32'h7FC00000, 1'b1};
      vecs[20] = '{32'h40200000, 32'h7F800001, 1'b0, 32'h40200000, 1'b1};

      rst = 1'b1;
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("reset_state", 32'h00000000, 1'b0, 1'b0);
      rst = 1'b0;

      // Back-to-back requests, each result one edge later.
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].rm, 1'b1);
         checkOutput($sformatf("vec%0d", i), vecs[i].expS,
                     expectedInvalid(vecs[i].expInv), 1'b1);
      end
      lastS = vecs[20].expS;

      // Idle edge: result held, valid drops, non-sticky NV clears.
      applyStimulus(32'h3F800000, 32'h40000000, 1'b1, 1'b0);
      checkOutput("idle_hold", lastS, expectedInvalid(1'b0), 1'b0);

      // Clean request after sNaN traffic.
      applyStimulus(32'h3F800000, 32'h40000000, 1'b1, 1'b1);
      checkOutput("clean_after_snan", 32'h40000000, expectedInvalid(1'b0), 1'b1);

      // Reset dominates a simultaneous sNaN request.
      rst = 1'b1;
      applyStimulus(32'h7F800001, 32'h3F800000, 1'b0, 1'b1);
      checkOutput("reset_with_valid", 32'h00000000, 1'b0, 1'b0);
      stickyModel = 1'b0;
      rst = 1'b0;

      applyStimulus(32'hBF800000, 32'h3F800000, 1'b0, 1'b1);
      checkOutput("post_reset_req", 32'hBF800000, expectedInvalid(1'b0), 1'b1);

      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("post_reset_idle", 32'hBF800000, expectedInvalid(1'b0), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
